// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields in, datapath control out, between datapath and controller
interface multicycle_control_if;
   logic [6:0] op_code;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       Zero;
   logic       adr_src;
   logic       mem_write;
   logic       IR_write;
   logic       reg_write;
   logic       PC_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_control;
   logic [3:0] state_out;
   logic       illegal_instr;
   logic       instr_done;
   modport master (
      output op_code, funct3, funct7, Zero,
      input  adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
             alu_src_a, alu_src_b, imm_src, alu_control, state_out, illegal_instr, instr_done
   );
   modport slave (
      input  op_code, funct3, funct7, Zero,
      output adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
             alu_src_a, alu_src_b, imm_src, alu_control, state_out, illegal_instr, instr_done
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute control FSM for a multicycle RV32I core
module multicycle_control #(
   parameter bit SYNC_MEM = 1'b1
) (
   input logic clk,
   input logic reset,
   multicycle_control_if.slave bus
);
   typedef enum logic [3:0] {
      FETCH_REQ, FETCH, DECODE, MEMADR, MEMREAD, MEMREAD_WAIT, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, TRAP
   } state_t;
   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic       IR_write;
      logic       reg_write;
      logic       PC_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] imm_src;
      logic [2:0] alu_control;
      logic       instr_done;
   } ctl_t;
   localparam state_t START = SYNC_MEM ? FETCH_REQ : FETCH;
   state_t     state_q, state_d;
   ctl_t       ctl_q, ctl_d, ctl_g;
   logic       illegal_q;
   logic [2:0] f3;
   logic       f7b;
   logic       is_load, is_store, is_r, is_i, is_br, is_jal, is_jalr;
   logic       bad_fn, taken;
   logic       unused_f7;
   assign f3        = bus.funct3;
   assign f7b       = bus.funct7[5];
   assign unused_f7 = ^{bus.funct7[6], bus.funct7[4:0]};
   assign is_load   = bus.op_code == 7'b0000011;
   assign is_store  = bus.op_code == 7'b0100011;
   assign is_r      = bus.op_code == 7'b0110011;
   assign is_i      = bus.op_code == 7'b0010011;
   assign is_br     = bus.op_code == 7'b1100011;
   assign is_jal    = bus.op_code == 7'b1101111;
   assign is_jalr   = bus.op_code == 7'b1100111 && f3 == 3'b000;
   // Encodings inside a legal opcode that this core does not implement (unsigned compares, arithmetic shifts)
   assign bad_fn = ((is_r || is_i) && (f3 == 3'b011 || (f3 == 3'b101 && f7b))) ||
                   (is_r && f7b && f3 != 3'b000 && f3 != 3'b101) ||
                   (is_br && (f3 == 3'b010 || f3 == 3'b011 || f3[2:1] == 2'b11));
   // blt/bge use slt, so a nonzero result means "less than"; eq/ne use sub
   assign taken = bus.Zero ^ (f3[0] ^ f3[2]);
   function automatic logic [2:0] exec_alu(input logic [2:0] f, input logic sub);
      return f == 3'b000 ? (sub ? 3'b001 : 3'b000) :
             f == 3'b001 ? 3'b110 :
             f == 3'b010 ? 3'b101 :
             f == 3'b100 ? 3'b100 :
             f == 3'b101 ? 3'b111 :
             f == 3'b110 ? 3'b011 :
             f == 3'b111 ? 3'b010 : 3'b000;
   endfunction
   function automatic ctl_t decode(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.IR_write   = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.PC_write   = 1'b1;
         end
         DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
            c.imm_src   = 2'b10;
         end
         MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.imm_src   = is_store ? 2'b01 : 2'b00;
         end
         MEMREAD, MEMREAD_WAIT: c.adr_src = 1'b1;
         MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         MEMWRITE: begin
            c.adr_src    = 1'b1;
            c.mem_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         EXECUTER: begin
            c.alu_src_a   = 2'b10;
            c.alu_control = exec_alu(f3, f7b);
         end
         EXECUTEI: begin
            c.alu_src_a   = 2'b10;
            c.alu_src_b   = 2'b01;
            c.alu_control = exec_alu(f3, 1'b0);
         end
         ALUWB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a   = 2'b10;
            c.imm_src     = 2'b10;
            c.alu_control = f3[2] ? 3'b101 : 3'b001;
            c.instr_done  = 1'b1;
         end
         JAL: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.PC_write  = 1'b1;
            c.imm_src   = 2'b11;
         end
         JALR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         default: c = '0;
      endcase
      return c;
   endfunction
   // Next state: one walk per instruction, TRAP parks until reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_REQ:    state_d = FETCH;
         FETCH:        state_d = DECODE;
         DECODE:       state_d = bad_fn ? TRAP :
                                 (is_load || is_store) ? MEMADR :
                                 is_r ? EXECUTER :
                                 is_i ? EXECUTEI :
                                 is_br ? BRANCH :
                                 is_jal ? JAL :
                                 is_jalr ? JALR : TRAP;
         MEMADR:       state_d = is_store ? MEMWRITE : MEMREAD;
         MEMREAD:      state_d = SYNC_MEM ? MEMREAD_WAIT : MEMWB;
         MEMREAD_WAIT: state_d = MEMWB;
         EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
         JALR:         state_d = JAL;
         TRAP:         state_d = TRAP;
         default:      state_d = START;
      endcase
   end
   assign ctl_d = decode(state_d);
   // State, Moore outputs for the coming state, and the sticky trap flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= START;
         ctl_q     <= decode(START);
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctl_q     <= ctl_d;
         illegal_q <= state_d == TRAP;
      end
   end
   assign ctl_g             = reset ? ctl_q : '0;
   assign bus.adr_src       = ctl_g.adr_src;
   assign bus.mem_write     = ctl_g.mem_write;
   assign bus.IR_write      = ctl_g.IR_write;
   assign bus.reg_write     = ctl_g.reg_write;
   assign bus.PC_write      = ctl_g.PC_write || (reset && state_q == BRANCH && taken);
   assign bus.result_src    = ctl_g.result_src;
   assign bus.alu_src_a     = ctl_g.alu_src_a;
   assign bus.alu_src_b     = ctl_g.alu_src_b;
   assign bus.imm_src       = ctl_g.imm_src;
   assign bus.alu_control   = ctl_g.alu_control;
   assign bus.instr_done    = ctl_g.instr_done;
   assign bus.state_out     = state_q;
   assign bus.illegal_instr = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed table, corner sequences and random instructions against a per-class model
module tb_multicycle_control;
   localparam int LOAD = 0, STORE = 1, RTYPE = 2, ITYPE = 3, BR = 4, JALC = 5, JALRC = 6, ILL = 7;
   typedef struct packed {
      logic       adr, mw, irw, rw, pcw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      logic       done, ill;
   } obs_t;
   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       z;
      int         lat;
      logic       ill;
      logic       pcw;
   } vec_t;
   logic       clk = 1'b0, reset = 1'b0, sel = 1'b1;
   logic [6:0] op = '0, f7 = '0;
   logic [2:0] f3 = '0;
   logic       zero = 1'b0;
   int         checks = 0, errors = 0;
   int         seq[$];
   logic       last_pcw, last_ill;
   obs_t       obs, obs1, obs0;
   logic [3:0] st;
   multicycle_control_if b1 ();
   multicycle_control_if b0 ();
   multicycle_control #(.SYNC_MEM(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   multicycle_control #(.SYNC_MEM(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   always #5 clk = ~clk;
   assign b1.op_code = op;
   assign b1.funct3  = f3;
   assign b1.funct7  = f7;
   assign b1.Zero    = zero;
   assign b0.op_code = op;
   assign b0.funct3  = f3;
   assign b0.funct7  = f7;
   assign b0.Zero    = zero;
   assign obs1 = {b1.adr_src, b1.mem_write, b1.IR_write, b1.reg_write, b1.PC_write, b1.result_src,
                  b1.alu_src_a, b1.alu_src_b, b1.imm_src, b1.alu_control, b1.instr_done, b1.illegal_instr};
   assign obs0 = {b0.adr_src, b0.mem_write, b0.IR_write, b0.reg_write, b0.PC_write, b0.result_src,
                  b0.alu_src_a, b0.alu_src_b, b0.imm_src, b0.alu_control, b0.instr_done, b0.illegal_instr};
   assign obs = sel ? obs1 : obs0;
   assign st  = sel ? b1.state_out : b0.state_out;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   function automatic int cls_of(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b);
      case (o)
         7'h03: return LOAD;
         7'h23: return STORE;
         7'h33: return (a == 3 || (b[5] && a != 0)) ? ILL : RTYPE;
         7'h13: return (a == 3 || (a == 5 && b[5])) ? ILL : ITYPE;
         7'h63: return (a == 2 || a == 3 || a == 6 || a == 7) ? ILL : BR;
         7'h6F: return JALC;
         7'h67: return a == 0 ? JALRC : ILL;
         default: return ILL;
      endcase
   endfunction
   task automatic build(input bit sync, input int c);
      seq = {};
      if (sync) seq.push_back(0);
      seq.push_back(1);
      seq.push_back(2);
      case (c)
         LOAD:  begin seq.push_back(3); seq.push_back(4); if (sync) seq.push_back(5); seq.push_back(6); end
         STORE: begin seq.push_back(3); seq.push_back(7); end
         RTYPE: begin seq.push_back(8); seq.push_back(10); end
         ITYPE: begin seq.push_back(9); seq.push_back(10); end
         BR:    seq.push_back(11);
         JALC:  begin seq.push_back(12); seq.push_back(10); end
         JALRC: begin seq.push_back(13); seq.push_back(12); seq.push_back(10); end
         default: seq.push_back(14);
      endcase
   endtask
   function automatic logic [2:0] alu_ex(input logic [2:0] a, input logic sub);
      case (a)
         3'd0: return sub ? 3'b001 : 3'b000;
         3'd1: return 3'b110;
         3'd2: return 3'b101;
         3'd4: return 3'b100;
         3'd5: return 3'b111;
         3'd6: return 3'b011;
         3'd7: return 3'b010;
         default: return 3'b000;
      endcase
   endfunction
   function automatic logic br_taken(input logic [2:0] a, input logic z);
      case (a)
         3'd0, 3'd5: return z;
         3'd1, 3'd4: return !z;
         default: return 1'b0;
      endcase
   endfunction
   function automatic obs_t exp_ctl(input int s, input int c, input logic [2:0] a, input logic b7, input logic z);
      obs_t e;
      e = '0;
      case (s)
         1:  begin e.irw = 1; e.sb = 2; e.rs = 2; e.pcw = 1; end
         2:  begin e.sa = 1; e.sb = 1; e.imm = 2; end
         3:  begin e.sa = 2; e.sb = 1; e.imm = (c == STORE) ? 2'd1 : 2'd0; end
         4, 5: e.adr = 1;
         6:  begin e.rs = 1; e.rw = 1; e.done = 1; end
         7:  begin e.adr = 1; e.mw = 1; e.done = 1; end
         8:  begin e.sa = 2; e.alu = alu_ex(a, b7); end
         9:  begin e.sa = 2; e.sb = 1; e.alu = alu_ex(a, 1'b0); end
         10: begin e.rw = 1; e.done = 1; end
         11: begin e.sa = 2; e.imm = 2; e.alu = a[2] ? 3'd5 : 3'd1; e.pcw = br_taken(a, z); e.done = 1; end
         12: begin e.sa = 1; e.sb = 2; e.pcw = 1; e.imm = 3; end
         13: begin e.sa = 2; e.sb = 1; end
         14: e.ill = 1;
         default: e = '0;
      endcase
      return e;
   endfunction
   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
   endtask
   task automatic run(input bit sync, input logic [6:0] o, input logic [2:0] a, input logic [6:0] b,
                      input logic z, input int trap_cycles, output int lat);
      int c, n;
      op = o; f3 = a; f7 = b; zero = z;
      c = cls_of(o, a, b);
      build(sync, c);
      n = seq.size() + (c == ILL ? trap_cycles - 1 : 0);
      lat = 0;
      last_pcw = 1'b0;
      for (int k = 0; k < n; k++) begin
         int s;
         s = k < seq.size() ? seq[k] : 14;
         @(negedge clk);
         chk($sformatf("cycle%0d_state%0d_op%h_f3%0d", k, s, o, a), {10'd0, st, obs},
             {10'd0, 4'(s), exp_ctl(s, c, a, b[5], z)});
         if (obs.done) begin lat = k + 1; last_pcw = obs.pcw; end
         last_ill = obs.ill;
         @(posedge clk);
         #1;
      end
      if (c == ILL) do_reset();
   endtask
   initial begin
      vec_t vt[19];
      int lat;
      vt = '{
         '{7'h13, 3'd0, 7'h00, 1'b0, 5, 1'b0, 1'b0},
         '{7'h03, 3'd2, 7'h00, 1'b0, 7, 1'b0, 1'b0},
         '{7'h23, 3'd2, 7'h00, 1'b0, 5, 1'b0, 1'b0},
         '{7'h63, 3'd0, 7'h00, 1'b1, 4, 1'b0, 1'b1},
         '{7'h63, 3'd0, 7'h00, 1'b0, 4, 1'b0, 1'b0},
         '{7'h63, 3'd5, 7'h00, 1'b1, 4, 1'b0, 1'b1},
         '{7'h63, 3'd4, 7'h00, 1'b1, 4, 1'b0, 1'b0},
         '{7'h63, 3'd1, 7'h00, 1'b0, 4, 1'b0, 1'b1},
         '{7'h6F, 3'd3, 7'h00, 1'b0, 5, 1'b0, 1'b0},
         '{7'h67, 3'd0, 7'h00, 1'b0, 6, 1'b0, 1'b0},
         '{7'h33, 3'd0, 7'h20, 1'b0, 5, 1'b0, 1'b0},
         '{7'h13, 3'd5, 7'h00, 1'b0, 5, 1'b0, 1'b0},
         '{7'h33, 3'd5, 7'h20, 1'b0, 0, 1'b1, 1'b0},
         '{7'h33, 3'd3, 7'h00, 1'b0, 0, 1'b1, 1'b0},
         '{7'h63, 3'd6, 7'h00, 1'b0, 0, 1'b1, 1'b0},
         '{7'h67, 3'd1, 7'h00, 1'b0, 0, 1'b1, 1'b0},
         '{7'h7F, 3'd0, 7'h00, 1'b0, 0, 1'b1, 1'b0},
         '{7'h13, 3'd5, 7'h20, 1'b0, 0, 1'b1, 1'b0},
         '{7'h33, 3'd7, 7'h20, 1'b0, 0, 1'b1, 1'b0}
      };
      @(negedge clk);
      chk("reset_sync_outputs", {10'd0, b1.state_out, obs1}, 32'd0);
      chk("reset_async_state", {28'd0, b0.state_out}, 32'd1);
      chk("reset_async_gated", {14'd0, obs0}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      sel = 1'b1;
      foreach (vt[i]) begin
         run(1'b1, vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, 2, lat);
         chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("vec%0d_illegal", i), {31'd0, last_ill}, {31'd0, vt[i].ill});
         if (!vt[i].ill) chk($sformatf("vec%0d_pc_write", i), {31'd0, last_pcw}, {31'd0, vt[i].pcw});
      end
      run(1'b1, 7'h33, 3'd5, 7'h20, 1'b0, 20, lat);
      @(negedge clk);
      chk("trap_cleared_by_reset", {27'd0, b1.illegal_instr, b1.state_out}, 32'd0);
      @(posedge clk);
      #1;
      op = 7'h23; f3 = 3'd2; f7 = '0;
      do_reset();
      repeat (4) @(posedge clk);
      #2;
      chk("memwrite_reached", {27'd0, b1.mem_write, b1.state_out}, {27'd1, 4'd7});
      reset = 1'b0;
      #1;
      chk("memwrite_gated_by_reset", {31'd0, b1.mem_write}, 32'd0);
      @(posedge clk);
      #1;
      chk("memwrite_reset_state", {27'd0, b1.illegal_instr, b1.state_out}, 32'd0);
      reset = 1'b1;
      repeat (150) begin
         logic [6:0] o;
         case ($urandom_range(0, 7))
            0: o = 7'h03; 1: o = 7'h23; 2: o = 7'h33; 3: o = 7'h13;
            4: o = 7'h63; 5: o = 7'h6F; 6: o = 7'h67; default: o = 7'($urandom);
         endcase
         run(1'b1, o, 3'($urandom), 7'($urandom), 1'($urandom), 3, lat);
      end
      sel = 1'b0;
      do_reset();
      run(1'b0, 7'h33, 3'd0, 7'h20, 1'b0, 2, lat);
      chk("async_sub_latency", lat, 4);
      run(1'b0, 7'h03, 3'd2, 7'h00, 1'b0, 2, lat);
      chk("async_load_latency", lat, 5);
      repeat (60) begin
         logic [6:0] o;
         case ($urandom_range(0, 7))
            0: o = 7'h03; 1: o = 7'h23; 2: o = 7'h33; 3: o = 7'h13;
            4: o = 7'h63; 5: o = 7'h6F; 6: o = 7'h67; default: o = 7'($urandom);
         endcase
         run(1'b0, o, 3'($urandom), 7'($urandom), 1'($urandom), 3, lat);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
